// File: rtl/controlador_contador.sv
// Sweep sequencer for a WIDTH-bit bidirectional saturating counter: clears it, climbs to lo,
// then ping-pongs lo->hi->lo for n_cycles, stopping with the count parked at lo.
module controlador_contador #(
  parameter int WIDTH    = 4,
  parameter int CYCLES_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [CYCLES_W-1:0] n_cycles,
  input  logic [WIDTH-1:0]    cnt_value,
  output logic                cnt_reset,
  output logic                cnt_enable,
  output logic                cnt_up_down,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CYCLES_W-1:0] cycles_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CLIMB,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [CYCLES_W-1:0] n_q, n_d;
  logic [CYCLES_W-1:0] cycles_done_q, cycles_done_d;
  logic                err_q, err_d;
  logic [CYCLES_W-1:0] cycles_inc;

  assign cycles_inc = cycles_done_q + {{(CYCLES_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      n_q           <= '0;
      cycles_done_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      n_q           <= n_d;
      cycles_done_q <= cycles_done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    n_d           = n_q;
    cycles_done_d = cycles_done_q;
    err_d         = 1'b0;
    cnt_reset     = 1'b0;
    cnt_enable    = 1'b0;
    cnt_up_down   = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Illegal programs are flagged without ever leaving IDLE.
          if ((lo > hi) || (n_cycles == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d       = S_INIT;
            lo_d          = lo;
            hi_d          = hi;
            n_d           = n_cycles;
            cycles_done_d = '0;
          end
        end
      end
      S_INIT: begin
        cnt_reset = 1'b1;
        state_d   = S_CLIMB;
      end
      S_CLIMB: begin
        cnt_up_down = 1'b1;
        cnt_enable  = (cnt_value != lo_q);
        if (cnt_value == lo_q) state_d = S_UP;
      end
      S_UP: begin
        cnt_up_down = 1'b1;
        cnt_enable  = (cnt_value != hi_q);
        if (cnt_value == hi_q) state_d = S_DOWN;
      end
      S_DOWN: begin
        cnt_up_down = 1'b0;
        cnt_enable  = (cnt_value != lo_q);
        if (cnt_value == lo_q) begin
          cycles_done_d = cycles_inc;
          state_d       = (cycles_inc == n_q) ? S_DONE : S_UP;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition and freezes the completed-cycle count.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      cycles_done_d = cycles_done_q;
    end
  end

  assign err         = err_q;
  assign cycles_done = cycles_done_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Bench for controlador_contador: a behavioural saturating counter closes the loop and a
// scoreboard of expected count traces and sweep results is checked cycle by cycle.
module tb_controlador_contador;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic [CW-1:0] n_cycles;
  logic [W-1:0]  cnt_value;
  logic          cnt_reset;
  logic          cnt_enable;
  logic          cnt_up_down;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] cycles_done;
  logic          cnt_init;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int lat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt[$];

  always #5 clk = ~clk;

  controlador_contador #(.WIDTH(W), .CYCLES_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .lo          (lo),
    .hi          (hi),
    .n_cycles    (n_cycles),
    .cnt_value   (cnt_value),
    .cnt_reset   (cnt_reset),
    .cnt_enable  (cnt_enable),
    .cnt_up_down (cnt_up_down),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cycles_done (cycles_done)
  );

  // The controlled counter: synchronous reset, enable, saturating up/down.
  always_ff @(posedge clk) begin
    if (cnt_init || cnt_reset) begin
      cnt_value <= '0;
    end else if (cnt_enable) begin
      if (cnt_up_down) begin
        if (cnt_value != 4'hF) cnt_value <= cnt_value + 4'd1;
      end else begin
        if (cnt_value != 4'h0) cnt_value <= cnt_value - 4'd1;
      end
    end
  end

  task automatic push_sweep(input int l, input int h, input int n);
    exp_t e;
    e.lat = 1 + (l + 1) + n * 2 * (h - l + 1) + 1;
    e.cyc = n;
    sb.push_back(e);
    exp_cnt.delete();
    for (int i = 0; i <= l; i++) exp_cnt.push_back(i);
    for (int c = 0; c < n; c++) begin
      for (int v = l; v <= h; v++) exp_cnt.push_back(v);
      for (int v = h; v >= l; v--) exp_cnt.push_back(v);
    end
    exp_cnt.push_back(l);
  endtask

  // Start is high during cycle 0; returns at the falling edge inside cycle 1.
  task automatic pulse_start(input int l, input int h, input int n);
    @(negedge clk);
    lo       = W'(l);
    hi       = W'(h);
    n_cycles = CW'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_sweep(input string name, input int glitch_k);
    exp_t e;
    int   k;
    int   prev_cd;
    int   exp_v;
    bit   seen_done;
    e = sb.pop_front();
    k = 1;
    prev_cd = 0;
    seen_done = 1'b0;
    checks++;
    if (cnt_reset !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_init: cnt_reset=%0b busy=%0b expected 1 1", name, cnt_reset, busy);
    end
    while (!seen_done && k < 400) begin
      @(negedge clk);
      k++;
      if (k == glitch_k) begin
        lo = 4'd0; hi = 4'd1; n_cycles = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      exp_v = (exp_cnt.size() > 0) ? exp_cnt.pop_front() : -1;
      checks++;
      if (int'(cnt_value) !== exp_v) begin
        failures++;
        $display("FAIL %s_cnt c%0d: got %0d expected %0d", name, k, cnt_value, exp_v);
      end
      checks++;
      if (busy !== 1'b1 || cnt_reset !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL %s_ctl c%0d: busy=%0b cnt_reset=%0b err=%0b expected 1 0 0",
                 name, k, busy, cnt_reset, err);
      end
      checks++;
      if (cnt_enable && ((cnt_up_down && cnt_value == 4'hF) || (!cnt_up_down && cnt_value == 4'h0))) begin
        failures++;
        $display("FAIL %s_sat c%0d: enable=1 at count %0d dir %0b expected enable 0",
                 name, k, cnt_value, cnt_up_down);
      end
      if (int'(cycles_done) != prev_cd) begin
        checks++;
        if (int'(cycles_done) !== prev_cd + 1) begin
          failures++;
          $display("FAIL %s_step c%0d: cycles_done=%0d expected %0d", name, k, cycles_done, prev_cd + 1);
        end
        prev_cd = int'(cycles_done);
      end
      if (done === 1'b1) seen_done = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!seen_done || k !== e.lat) begin
      failures++;
      $display("FAIL %s_latency: done at %0d (seen=%0b) expected %0d", name, k, seen_done, e.lat);
    end
    checks++;
    if (int'(cycles_done) !== e.cyc) begin
      failures++;
      $display("FAIL %s_cycles: got %0d expected %0d", name, cycles_done, e.cyc);
    end
    checks++;
    if (exp_cnt.size() != 0) begin
      failures++;
      $display("FAIL %s_trace_len: %0d samples left expected 0", name, exp_cnt.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: busy=%0b done=%0b expected 0 0", name, busy, done);
    end
    $display("sweep %s: lat=%0d cycles_done=%0d", name, k, cycles_done);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, err, cnt_reset, cnt_enable, cnt_up_down} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs: got %06b expected 000000",
               {busy, done, err, cnt_reset, cnt_enable, cnt_up_down});
    end
    checks++;
    if (cycles_done !== 4'd0) begin
      failures++;
      $display("FAIL reset_cycles: got %0d expected 0", cycles_done);
    end
    $display("reset: busy=%0b cycles_done=%0d", busy, cycles_done);
  endtask

  task automatic test_illegal(input int l, input int h, input int n);
    pulse_start(l, h, n);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt_reset !== 1'b0 || cnt_enable !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse lo=%0d hi=%0d n=%0d: err=%0b busy=%0b rst=%0b en=%0b expected 1 0 0 0",
               l, h, n, err, busy, cnt_reset, cnt_enable);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || cnt_reset !== 1'b0 || cnt_enable !== 1'b0) begin
      failures++;
      $display("FAIL illegal_after lo=%0d hi=%0d n=%0d: err=%0b busy=%0b rst=%0b en=%0b expected 0 0 0 0",
               l, h, n, err, busy, cnt_reset, cnt_enable);
    end
    $display("illegal lo=%0d hi=%0d n=%0d: err pulse checked", l, h, n);
  endtask

  task automatic test_abort();
    int k;
    int done_seen;
    pulse_start(2, 5, 4);
    k = 1;
    while (k < 14) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b1 || cnt_up_down !== 1'b1 || cycles_done !== 4'd1 || cnt_value !== 4'd3) begin
      failures++;
      $display("FAIL abort_pre: busy=%0b up=%0b cd=%0d cnt=%0d expected 1 1 1 3",
               busy, cnt_up_down, cycles_done, cnt_value);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0 || cnt_reset !== 1'b0 || cycles_done !== 4'd1) begin
      failures++;
      $display("FAIL abort_post: busy=%0b en=%0b rst=%0b cd=%0d expected 0 0 0 1",
               busy, cnt_enable, cnt_reset, cycles_done);
    end
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || cycles_done !== 4'd1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL abort_idle: %0d bad cycles after abort expected 0", done_seen);
    end
    $display("abort: cycles_done held at %0d", cycles_done);
  endtask

  task automatic test_reset_mid();
    int k;
    pulse_start(2, 5, 1);
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b1 || cnt_up_down !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: busy=%0b up=%0b expected 1 0", busy, cnt_up_down);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, cnt_reset, cnt_enable, cnt_up_down} !== 6'b0 || cycles_done !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_outs: got %06b cd=%0d expected 000000 0",
               {busy, done, err, cnt_reset, cnt_enable, cnt_up_down}, cycles_done);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset mid-sweep: counter left at %0d", cnt_value);
    push_sweep(2, 5, 1);
    pulse_start(2, 5, 1);
    run_sweep("restart", 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; n_cycles = '0; cnt_init = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    cnt_init = 1'b0;
    @(negedge clk);
    test_reset();

    push_sweep(2, 5, 1);
    pulse_start(2, 5, 1);
    run_sweep("basic", 0);

    push_sweep(0, 15, 3);
    pulse_start(0, 15, 3);
    run_sweep("full", 0);

    push_sweep(7, 7, 2);
    pulse_start(7, 7, 2);
    run_sweep("equal", 0);

    test_illegal(9, 3, 1);
    test_illegal(2, 5, 0);

    test_abort();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
